data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Shares the single-port data memory (comb read, posedge byte-masked write) between two
//  requesters: port 0 = core load/store unit, port 1 = debug/DMA loader.
//  Round-robin arbitration, optional bus lock for atomic read-modify-write, lock-timeout watchdog.
//  Sits between the requesters and the memory instance.
// PARAMETERS
//  ADDR_BITS     rv_config::DATA_BITS-2  word-address width (matches memory address port)
//  LOCK_TIMEOUT  16                      max cycles a lock may be held before forced release (>=2)
// PORTS
//  clock        in   1          system clock, all state on posedge
//  reset_n      in   1          asynchronous, active-low reset
//  req0/req1    in   1          port k request; held stable until accepted
//  lock0/lock1  in   1          port k asks to keep ownership after this transfer
//  addr0/addr1  in   ADDR_BITS  word address
//  wren0/wren1  in   1          1 = write, 0 = read
//  be0/be1      in   4          byte enables (writes only)
//  wdata0/wdata1 in  32         write data
//  gnt0/gnt1    out  1          comb: transfer accepted this cycle (req & gnt)
//  rvalid0/rvalid1 out 1        registered: read data valid, one cycle after accepted read
//  rdata0/rdata1 out 32         registered read data, held until next read on that port
//  lock_err0/lock_err1 out 1    one-cycle pulse: port k lock forcibly released by timeout
//  mem_address  out  ADDR_BITS  to memory address
//  mem_wren     out  1          to memory wren
//  mem_byteena  out  4          to memory byteena
//  mem_data     out  32         to memory data
//  mem_q        in   32         from memory q (comb on mem_address)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, last_gnt=1, lock_cnt=0; rvalid*=0, rdata*=0, lock_err*=0.
//   In-flight read dropped: no rvalid after reset release. gnt* comb: 0 while reset_n=0.
//  States: IDLE, OWN0, OWN1.
//  IDLE: single req -> grant it; both req -> grant port != last_gnt (port 0 wins first tie).
//   Granted port k with lock_k=1 -> OWNk, lock_cnt=0. last_gnt<=k on every grant.
//  OWNk: only port k may be granted; other port stalls (gnt=0, request held).
//   lock_k=0 (sampled any cycle) -> IDLE. lock_cnt++ each cycle in OWNk;
//   lock_cnt==LOCK_TIMEOUT-1 with lock_k still 1 -> IDLE, lock_err_k pulse, last_gnt=k
//   (so the other port wins the next tie).
//  Memory mux (comb): granted port drives mem_address/mem_byteena/mem_data;
//   mem_wren = gnt_k & wren_k. No grant: mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
//  Write: commits at the posedge of the grant cycle; no response.
//  Read: accepted cycle captures mem_q into rdata_k; rvalid_k=1 the next cycle only.
//   Back-to-back reads sustain 1/cycle. A write with be=0 is accepted and is a no-op.
//  Simultaneous: at most one grant per cycle. A read by k followed by a write by the other port
//   returns the pre-write word. Lock request while already in OWNk extends ownership;
//   lock from the non-owner is ignored until it is granted.
//  Timeout count: lock_cnt is clog2(LOCK_TIMEOUT) bits; no wrap (reset on exit).
// STRUCTURE
//  Shared package dmem_arb_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;
//   localparam ARB_PORTS=2; typedef logic[ADDR_BITS-1:0] dmem_addr_t.
//  One sub-module: rr_pick2 (comb 2-way round-robin picker: req[1:0], last -> gnt[1:0]).
//  Remainder in this module: FSM, lock counter, memory mux, read-response registers.
// TESTING
//  1 Reset: reset_n=0 mid-read -> rvalid0 stays 0 after release; all outputs 0; next tie goes to port 0.
//  2 Write/read: p0 writes 0xDEADBEEF be=4'b1111 @0x10, then be=4'b0010 data 0x0000AA00
//    -> p0 read @0x10 gives rvalid0 next cycle, rdata0=0xDEADAAEF.
//  3 Contention: req0=req1=1 for 4 cycles (reads) -> grants alternate 0,1,0,1; each rvalid one cycle later.
//  4 Lock: p1 read+lock, p0 requesting -> p1 gets 3 consecutive grants (RMW);
//    p0 granted the cycle after lock1 drops.
//  5 Timeout: p0 holds lock0=1, LOCK_TIMEOUT=16 -> lock_err0 pulses on cycle 16 of ownership;
//    p1 granted next cycle.
//  6 Ordering: p0 read @0x20 and p1 write 0x12345678 @0x20 same cycle, last_gnt=1
//    -> p0 first gets old data; a later read returns 0x12345678.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port count and word-address type.
package dmem_arb_pkg;

  localparam int DMEM_DATA_BITS = 32;
  localparam int DMEM_ADDR_BITS = DMEM_DATA_BITS - 2;
  localparam int ARB_PORTS      = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  typedef logic [DMEM_ADDR_BITS-1:0] dmem_addr_t;

endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the debug/DMA loader (port 1),
// with round-robin arbitration, an optional bus lock for read-modify-write and a lock-timeout watchdog.
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_BITS    = DMEM_ADDR_BITS,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic                 wren0,
  input  logic                 wren1,
  input  logic [3:0]           be0,
  input  logic [3:0]           be1,
  input  logic [31:0]          wdata0,
  input  logic [31:0]          wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [31:0]          rdata0,
  output logic [31:0]          rdata1,
  output logic                 lock_err0,
  output logic                 lock_err1,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_wren,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  input  logic [31:0]          mem_q
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  arb_state_t       state, state_next;
  logic             last_gnt, last_gnt_next;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic [1:0]       pick;
  logic [1:0]       gnt;
  logic [1:0]       lock_err;
  logic             rd0, rd1;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (last_gnt),
    .gnt  (pick)
  );

  // Only the owner may be granted while a lock is held; nothing is granted during reset.
  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      unique case (state)
        ARB_IDLE: gnt = pick;
        ARB_OWN0: gnt = {1'b0, req0};
        ARB_OWN1: gnt = {req1, 1'b0};
        default:  gnt = 2'b00;
      endcase
    end
  end

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign lock_err0 = lock_err[0];
  assign lock_err1 = lock_err[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    last_gnt_next = last_gnt;
    lock_err      = 2'b00;
    if (gnt[0]) begin
      last_gnt_next = 1'b0;
    end else if (gnt[1]) begin
      last_gnt_next = 1'b1;
    end
    unique case (state)
      ARB_IDLE: begin
        lock_cnt_next = '0;
        if (gnt[0] && lock0) begin
          state_next = ARB_OWN0;
        end else if (gnt[1] && lock1) begin
          state_next = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!lock0) begin
          state_next    = ARB_IDLE;
          lock_cnt_next = '0;
        end else if (lock_cnt == CNT_LAST) begin
          // Forced release hands the next tie to the other port.
          state_next    = ARB_IDLE;
          lock_cnt_next = '0;
          lock_err[0]   = 1'b1;
          last_gnt_next = 1'b0;
        end else begin
          lock_cnt_next = lock_cnt + 1'b1;
        end
      end
      ARB_OWN1: begin
        if (!lock1) begin
          state_next    = ARB_IDLE;
          lock_cnt_next = '0;
        end else if (lock_cnt == CNT_LAST) begin
          state_next    = ARB_IDLE;
          lock_cnt_next = '0;
          lock_err[1]   = 1'b1;
          last_gnt_next = 1'b1;
        end else begin
          lock_cnt_next = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_next    = ARB_IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    mem_address = '0;
    mem_byteena = 4'b0000;
    mem_data    = 32'd0;
    mem_wren    = 1'b0;
    if (gnt[0]) begin
      mem_address = addr0;
      mem_byteena = be0;
      mem_data    = wdata0;
      mem_wren    = wren0;
    end else if (gnt[1]) begin
      mem_address = addr1;
      mem_byteena = be1;
      mem_data    = wdata1;
      mem_wren    = wren1;
    end
  end

  assign rd0 = gnt[0] & ~wren0;
  assign rd1 = gnt[1] & ~wren1;

  // Read response stage: memory is combinational, so the word is captured in the accept cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= 32'd0;
      rdata1  <= 32'd0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) begin
        rdata0 <= mem_q;
      end
      if (rd1) begin
        rdata1 <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_data_memory_arbiter;

  localparam int AW = 30;
  localparam int LT = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req, lock, wren;
  logic [7:0]  a  [2];
  logic [3:0]  be [2];
  logic [31:0] wd [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, lock_err0, lock_err1;
  logic [31:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic        mem_wren;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data, mem_q;

  data_memory_arbiter #(.ADDR_BITS(AW), .LOCK_TIMEOUT(LT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req[0]), .req1(req[1]), .lock0(lock[0]), .lock1(lock[1]),
    .addr0({22'd0, a[0]}), .addr1({22'd0, a[1]}),
    .wren0(wren[0]), .wren1(wren[1]), .be0(be[0]), .be1(be[1]),
    .wdata0(wd[0]), .wdata1(wd[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .lock_err0(lock_err0), .lock_err1(lock_err1),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Memory instance model: combinational read, byte-masked posedge write, plus a preload path.
  logic [31:0] mem [256];
  logic        init_en;
  logic [7:0]  init_idx;
  logic [31:0] init_val;
  always @(posedge clock) begin
    if (init_en) mem[init_idx] <= init_val;
    else if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) mem[mem_address[7:0]][8*b +: 8] <= mem_data[8*b +: 8];
  end
  assign mem_q = mem[mem_address[7:0]];

  // Reference model state: owner -1 means nobody holds the bus.
  int          m_owner, m_last, m_held;
  logic [31:0] ref_mem [256];
  logic [1:0]  m_rv;
  logic [31:0] m_rd [2];
  int          e_k;
  logic [1:0]  e_gnt, e_err;
  logic        ew;
  logic [3:0]  ebe;
  logic [AW-1:0] ea;
  logic [31:0] ed;
  logic [136:0] obs, expv;
  logic [1:0]  o_gnt, o_err;
  int total = 0;
  int bad = 0;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_held = 0; m_rv = 2'b00;
    m_rd[0] = 32'd0; m_rd[1] = 32'd0;
  endtask

  task automatic model_eval();
    e_k = -1; e_gnt = 2'b00; e_err = 2'b00;
    if (m_owner < 0) begin
      if (req == 2'b11) e_k = (m_last == 0) ? 1 : 0;
      else if (req[0]) e_k = 0;
      else if (req[1]) e_k = 1;
    end else begin
      if (req[m_owner]) e_k = m_owner;
      if (lock[m_owner] && m_held == LT - 1) e_err[m_owner] = 1'b1;
    end
    ew = 1'b0; ebe = 4'd0; ea = '0; ed = 32'd0;
    if (e_k >= 0) begin
      e_gnt[e_k] = 1'b1;
      ew = wren[e_k]; ebe = be[e_k]; ea = {22'd0, a[e_k]}; ed = wd[e_k];
    end
  endtask

  task automatic model_commit();
    logic [1:0] nrv;
    nrv = 2'b00;
    if (e_k >= 0) begin
      m_last = e_k;
      if (!wren[e_k]) begin
        nrv[e_k] = 1'b1;
        m_rd[e_k] = ref_mem[a[e_k]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[e_k][b]) ref_mem[a[e_k]][8*b +: 8] = wd[e_k][8*b +: 8];
      end
    end
    m_rv = nrv;
    if (m_owner < 0) begin
      if (e_k >= 0 && lock[e_k]) begin m_owner = e_k; m_held = 0; end
    end else if (!lock[m_owner]) begin
      m_owner = -1;
    end else if (m_held == LT - 1) begin
      m_last = m_owner; m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    model_eval();
    o_gnt = {gnt1, gnt0};
    o_err = {lock_err1, lock_err0};
    obs  = {gnt1, gnt0, lock_err1, lock_err0, rvalid1, rvalid0, rdata1, rdata0,
            mem_wren, mem_byteena, mem_address, mem_data};
    expv = {e_gnt, e_err, m_rv, m_rd[1], m_rd[0], ew, ebe, ea, ed};
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic set_port(int p, logic rq, logic lk, logic we, logic [7:0] ad,
                          logic [3:0] bm, logic [31:0] dt);
    req[p] = rq; lock[p] = lk; wren[p] = we; a[p] = ad; be[p] = bm; wd[p] = dt;
  endtask

  task automatic idle_all();
    set_port(0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 32'd0);
  endtask

  task automatic test_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 8'd5, 4'd0, 32'd0);
    @(negedge clock);
    total++;
    if (gnt0 !== 1'b1) begin bad++; $display("FAIL reset_pre_gnt0 got=%b want=1", gnt0); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lock_err0, lock_err1, mem_wren,
         mem_byteena, mem_address, mem_data} !== '0) begin
      bad++; $display("FAIL reset_outputs gnt=%b%b rv=%b%b rd0=%h rd1=%h want all zero",
                      gnt1, gnt0, rvalid1, rvalid0, rdata0, rdata1);
    end
    @(posedge clock); #1;
    total++;
    if (rvalid0 !== 1'b0) begin bad++; $display("FAIL reset_in_flight rvalid0=%b want=0", rvalid0); end
    idle_all();
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    @(posedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      tick(); total++;
      if (obs !== expv) begin bad++; $display("FAIL reset_release c%0d got=%h want=%h", i, obs, expv); end
      total++;
      if (rvalid0 !== 1'b0) begin bad++; $display("FAIL reset_no_rvalid c%0d rvalid0=%b want=0", i, rvalid0); end
    end
    set_port(0, 1'b1, 1'b0, 1'b0, 8'd6, 4'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 1'b0, 8'd7, 4'd0, 32'd0);
    tick(); total++;
    if (o_gnt !== 2'b01) begin bad++; $display("FAIL reset_first_tie got=%b want=01", o_gnt); end
    req[0] = 1'b0;
    tick(); total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_tie_second got=%h want=%h", obs, expv); end
    idle_all();
    tick();
  endtask

  task automatic test_write_read();
    set_port(0, 1'b1, 1'b0, 1'b1, 8'h10, 4'b1111, 32'hDEADBEEF);
    tick(); total++;
    if (obs !== expv) begin bad++; $display("FAIL wr_full got=%h want=%h", obs, expv); end
    set_port(0, 1'b1, 1'b0, 1'b1, 8'h10, 4'b0010, 32'h0000AA00);
    tick(); total++;
    if (obs !== expv) begin bad++; $display("FAIL wr_byte got=%h want=%h", obs, expv); end
    set_port(0, 1'b1, 1'b0, 1'b1, 8'h10, 4'b0000, 32'h11111111);
    tick(); total++;
    if (obs !== expv) begin bad++; $display("FAIL wr_be0 got=%h want=%h", obs, expv); end
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h10, 4'b0000, 32'd0);
    tick(); total++;
    if ({rvalid0, rdata0} !== {1'b1, 32'hDEADAAEF}) begin
      bad++; $display("FAIL wr_readback rvalid0=%b rdata0=%h want=1 deadaaef", rvalid0, rdata0);
    end
    idle_all();
    tick(); total++;
    if ({rvalid0, rdata0} !== {1'b0, 32'hDEADAAEF}) begin
      bad++; $display("FAIL wr_hold rvalid0=%b rdata0=%h want=0 deadaaef", rvalid0, rdata0);
    end
  endtask

  task automatic test_contention();
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h40, 4'd0, 32'd0);
    tick(); req[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 4'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); total++;
      if (o_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL contend_order c%0d got=%b", i, o_gnt);
      end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL contend_model c%0d got=%h want=%h", i, obs, expv); end
      a[(i % 2 == 0) ? 0 : 1] = 8'($urandom_range(0, 255));
    end
    idle_all();
    tick(); total++;
    if (obs !== expv) begin bad++; $display("FAIL contend_tail got=%h want=%h", obs, expv); end
  endtask

  task automatic test_lock();
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h31, 4'd0, 32'd0);
    tick(); req[0] = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h31, 4'd0, 32'd0);
    set_port(1, 1'b1, 1'b1, 1'b0, 8'h30, 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_port(1, 1'b1, 1'b0, 1'b1, 8'h30, 4'b1111, m_rd[1] + 32'd1);
      if (i == 3) req[1] = 1'b0;
      tick(); total++;
      if (o_gnt !== ((i < 3) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL lock_rmw c%0d got=%b", i, o_gnt);
      end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL lock_model c%0d got=%h want=%h", i, obs, expv); end
    end
    idle_all();
    tick();
  endtask

  task automatic test_timeout();
    set_port(0, 1'b1, 1'b1, 1'b0, 8'h50, 4'd0, 32'd0);
    tick();
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h51, 4'd0, 32'd0);
    for (int i = 1; i <= 17; i++) begin
      a[0] = 8'($urandom_range(0, 255));
      tick(); total++;
      if (o_err !== ((i == 16) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL timeout_err c%0d got=%b", i, o_err);
      end
      total++;
      if (o_gnt !== ((i == 17) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL timeout_gnt c%0d got=%b", i, o_gnt);
      end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL timeout_model c%0d got=%h want=%h", i, obs, expv); end
    end
    idle_all();
    tick(); tick();
  endtask

  task automatic test_ordering();
    logic [31:0] old;
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h21, 4'd0, 32'd0);
    tick(); req[1] = 1'b0;
    old = ref_mem[8'h20];
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h20, 4'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 1'b1, 8'h20, 4'b1111, 32'h12345678);
    tick(); total++;
    if ({o_gnt, rvalid0, rdata0} !== {2'b01, 1'b1, old}) begin
      bad++; $display("FAIL order_old gnt=%b rdata0=%h want=01 %h", o_gnt, rdata0, old);
    end
    req[0] = 1'b0;
    tick(); total++;
    if (o_gnt !== 2'b10) begin bad++; $display("FAIL order_write gnt=%b want=10", o_gnt); end
    req[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 8'h20, 4'd0, 32'd0);
    tick(); total++;
    if (rdata0 !== 32'h12345678) begin
      bad++; $display("FAIL order_new rdata0=%h want=12345678", rdata0);
    end
    idle_all();
    tick();
  endtask

  task automatic test_random();
    idle_all();
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            set_port(p, 1'b1,
                     (m_owner == p) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                     4'($urandom), $urandom);
          end else begin
            lock[p] = lock[p] & ($urandom_range(0, 7) != 0);
          end
        end
      end
      tick(); total++;
      if (obs !== expv) begin bad++; $display("FAIL random c%0d got=%h want=%h", i, obs, expv); end
      for (int p = 0; p < 2; p++) if (e_gnt[p]) req[p] = 1'b0;
    end
    idle_all();
    tick();
  endtask

  initial begin
    idle_all();
    reset_n = 1'b0;
    init_en = 1'b1;
    init_idx = 8'd0;
    init_val = 32'd0;
    for (int i = 0; i < 256; i++) begin
      init_idx = 8'(i);
      init_val = $urandom;
      ref_mem[i] = init_val;
      @(posedge clock); #1;
    end
    init_en = 1'b0;
    reset_n = 1'b1;
    model_reset();
    @(posedge clock); #1;
    test_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_timeout();
    test_ordering();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
